// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types plus the coherence controller state encoding.
// Types only; no latency and no flow control of its own.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WB    = 3'd1,
    SNOOP = 3'd2,
    C2C   = 3'd3,
    RAMRD = 3'd4,
    INV   = 3'd5
  } cc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin pick: a lone request wins, and a tie goes to the core that did not win last.
// Purely combinational; the grant is only meaningful while some request is high.
module rr_arbiter (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/coherence_ctrl.sv
// Bus-locking MSI snoop controller for two dcaches sharing one RAM port; outputs are combinational from state.
// A word completes in the cycle RAM reports ACCESS; every other RAM state keeps dwait high.
module coherence_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [CPUS-1:0]     dREN,
  input  logic [CPUS-1:0]     dWEN,
  input  word_t [CPUS-1:0]    daddr,
  input  word_t [CPUS-1:0]    dstore,
  input  logic [CPUS-1:0]     cctrans,
  input  logic [CPUS-1:0]     ccwrite,
  output logic [CPUS-1:0]     dwait,
  output word_t [CPUS-1:0]    dload,
  output logic [CPUS-1:0]     ccwait,
  output logic [CPUS-1:0]     ccinv,
  output word_t [CPUS-1:0]    ccsnoopaddr,
  output word_t               ramaddr,
  output word_t               ramstore,
  output logic                ramREN,
  output logic                ramWEN,
  input  word_t               ramload,
  input  ramstate_t           ramstate
);

  cc_state_t       state_q, state_n;
  logic            grant_q, grant_n;
  logic            last_q, last_n;
  logic            pick;
  logic            r, s;
  logic            access;
  logic [CPUS-1:0] elig;

  assign r      = grant_q;
  assign s      = ~grant_q;
  assign access = (ramstate == ACCESS);
  assign elig   = dREN | dWEN | (cctrans & ccwrite);

  rr_arbiter u_arb (
    .req   (elig),
    .last  (last_q),
    .grant (pick)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      last_q  <= last_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    grant_n     = grant_q;
    last_n      = last_q;
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state_q)
      IDLE: begin
        if (|elig) begin
          grant_n = pick;
          last_n  = pick;
          if (dWEN[pick])      state_n = WB;
          else if (dREN[pick]) state_n = SNOOP;
          else                 state_n = INV;
        end
      end

      // The write strobe follows dWEN so the release cycle cannot commit a stale word.
      WB: begin
        if (dWEN[r]) begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[r];
          ramstore = dstore[r];
          if (access) dwait[r] = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end

      SNOOP: begin
        ccwait[s]      = 1'b1;
        ccinv[s]       = ccwrite[r];
        ccsnoopaddr[s] = {daddr[r][31:3], 3'b000};
        if (cctrans[s]) state_n = ccwrite[s] ? C2C : RAMRD;
      end

      // Dirty line: the snooper feeds the requester and RAM in the same cycle.
      C2C: begin
        ccwait[s] = 1'b1;
        if (dREN[r]) begin
          dload[r] = dstore[s];
          ramWEN   = 1'b1;
          ramaddr  = daddr[s];
          ramstore = dstore[s];
          if (access) begin
            dwait[r] = 1'b0;
            dwait[s] = 1'b0;
            if (daddr[r][2]) state_n = IDLE;
          end
        end else begin
          state_n = IDLE;
        end
      end

      RAMRD: begin
        if (dREN[r]) begin
          ramREN   = 1'b1;
          ramaddr  = daddr[r];
          dload[r] = ramload;
          if (access) begin
            dwait[r] = 1'b0;
            if (daddr[r][2]) state_n = IDLE;
          end
        end else begin
          state_n = IDLE;
        end
      end

      INV: begin
        ccwait[s]      = 1'b1;
        ccinv[s]       = 1'b1;
        ccsnoopaddr[s] = daddr[r];
        if (cctrans[s]) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_ctrl.sv
// Bench for coherence_ctrl: acts as both dcaches plus a latency-programmable RAM,
// and predicts data from a word-level memory image and round-robin grant history.
module tb_coherence_ctrl;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  dREN, dWEN, cctrans, ccwrite;
  logic [1:0]  dwait, ccwait, ccinv;
  word_t [1:0] daddr, dstore, dload, ccsnoopaddr;
  word_t       ramaddr, ramstore, ramload;
  logic        ramREN, ramWEN;
  ramstate_t   ramstate;

  int    checks = 0;
  int    passed = 0;
  int    lat = 2;
  int    cnt = 0;
  bit    ram_err = 1'b0;
  bit    ram_ready = 1'b0;
  int    model_last = 1;
  word_t ram [256];
  word_t exp_mem [256];

  always #5 CLK = ~CLK;

  coherence_ctrl #(.CPUS(2)) dut (
    .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload), .ccwait(ccwait),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramload(ramload), .ramstate(ramstate)
  );

  function automatic int ix(input word_t a);
    return int'(a[9:2]);
  endfunction

  function automatic word_t init_val(input int i);
    return word_t'(32'h1000_0000 + i * 32'h0001_0101);
  endfunction

  function automatic word_t rand_base();
    return word_t'($urandom_range(0, 127)) << 3;
  endfunction

  // RAM: ACCESS once a request has been held for `lat` cycles.
  always_comb begin
    if (!(ramREN || ramWEN)) ramstate = FREE;
    else if (ram_err)        ramstate = ERROR;
    else if (cnt >= lat)     ramstate = ACCESS;
    else                     ramstate = BUSY;
  end

  assign ramload = ram[ramaddr[9:2]];

  always @(posedge CLK) begin
    cnt <= ((ramREN || ramWEN) && ramstate != ACCESS) ? cnt + 1 : 0;
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (ramWEN && ramstate == ACCESS) begin
      ram[ramaddr[9:2]] <= ramstore;
    end
  end

  task automatic clear_reqs();
    dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
  endtask

  task automatic test_reset();
    clear_reqs(); daddr = '0; dstore = '0;
    nRST = 1'b0;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if ({dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore} !== {2'b11, 198'b0})
      $display("FAIL reset_idle: got dwait=%b ccwait=%b ramREN=%b ramWEN=%b want defaults", dwait, ccwait, ramREN, ramWEN);
    else passed++;
    dREN = 2'b11; dWEN = 2'b01;
    @(negedge CLK); #1;
    checks++;
    if ({dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore} !== {2'b11, 198'b0})
      $display("FAIL reset_held_reqs: got dwait=%b ramREN=%b ramWEN=%b want defaults", dwait, ramREN, ramWEN);
    else passed++;
    clear_reqs();
    @(negedge CLK); nRST = 1'b1;
    model_last = 1;
  endtask

  task automatic run_read(input int c, input word_t base, input bit ccw, input bit dirty,
                          input word_t d0, input word_t d1);
    int s = 1 - c;
    int w = 0;
    int cyc = 0;
    int snoops = 0;
    int spulse = 0;
    word_t wexp;
    while (w < 2 && cyc < 100) begin
      @(negedge CLK); cyc++;
      dREN[c] = 1'b1; cctrans[c] = 1'b1; ccwrite[c] = ccw; daddr[c] = base + word_t'(4 * w);
      #1;
      if (ccwait[s]) begin
        if (snoops == 0) begin
          checks++;
          if (ccsnoopaddr[s] !== base || ccinv[s] !== ccw)
            $display("FAIL snoop_req core%0d: got addr=%h inv=%b want addr=%h inv=%b", s, ccsnoopaddr[s], ccinv[s], base, ccw);
          else passed++;
        end
        snoops++;
        cctrans[s] = 1'b1; ccwrite[s] = dirty; daddr[s] = daddr[c]; dstore[s] = (w == 0) ? d0 : d1;
      end else begin
        cctrans[s] = 1'b0; ccwrite[s] = 1'b0;
      end
      #1;
      if (dwait[s] == 1'b0) spulse++;
      if (dwait[c] == 1'b0) begin
        wexp = dirty ? ((w == 0) ? d0 : d1) : exp_mem[ix(daddr[c])];
        checks++;
        if (dload[c] !== wexp)
          $display("FAIL read_data core%0d word%0d: got %h want %h", c, w, dload[c], wexp);
        else passed++;
        checks++;
        if (dirty ? (ramWEN !== 1'b1 || ramaddr !== daddr[c] || ramstore !== wexp)
                  : (ramREN !== 1'b1 || ramaddr !== daddr[c]))
          $display("FAIL read_ram_port core%0d word%0d: got ren=%b wen=%b addr=%h store=%h want dirty=%b addr=%h",
                   c, w, ramREN, ramWEN, ramaddr, ramstore, dirty, daddr[c]);
        else passed++;
        if (dirty) exp_mem[ix(daddr[c])] = wexp;
        w++;
      end
    end
    checks++;
    if (w != 2) $display("FAIL read_timeout core%0d: got %0d words want 2", c, w);
    else passed++;
    @(negedge CLK);
    clear_reqs();
    #1;
    checks++;
    if (dwait !== 2'b11 || ccwait !== 2'b00 || ramREN !== 1'b0 || ramWEN !== 1'b0)
      $display("FAIL read_release: got dwait=%b ccwait=%b ren=%b wen=%b want 11/00/0/0", dwait, ccwait, ramREN, ramWEN);
    else passed++;
    checks++;
    if (snoops < 1 || spulse != (dirty ? 2 : 0))
      $display("FAIL read_snoop_pulses: got snoops=%0d peer_pulses=%0d want >=1/%0d", snoops, spulse, dirty ? 2 : 0);
    else passed++;
    checks++;
    if (ram[ix(base)] !== exp_mem[ix(base)] || ram[ix(base) + 1] !== exp_mem[ix(base) + 1])
      $display("FAIL read_mem_image %h: got %h %h want %h %h", base, ram[ix(base)], ram[ix(base) + 1],
               exp_mem[ix(base)], exp_mem[ix(base) + 1]);
    else passed++;
    model_last = c;
  endtask

  task automatic run_wb(input int c, input word_t base, input word_t d0, input word_t d1);
    int w = 0;
    int cyc = 0;
    while (w < 2 && cyc < 100) begin
      @(negedge CLK); cyc++;
      dWEN[c] = 1'b1; daddr[c] = base + word_t'(4 * w); dstore[c] = (w == 0) ? d0 : d1;
      #1;
      if (dwait[c] == 1'b0) begin
        checks++;
        if (ramWEN !== 1'b1 || ramaddr !== daddr[c] || ramstore !== dstore[c])
          $display("FAIL wb_port core%0d word%0d: got wen=%b addr=%h data=%h want 1/%h/%h", c, w, ramWEN, ramaddr, ramstore, daddr[c], dstore[c]);
        else passed++;
        exp_mem[ix(daddr[c])] = dstore[c];
        w++;
      end
    end
    checks++;
    if (w != 2) $display("FAIL wb_timeout core%0d: got %0d words want 2", c, w);
    else passed++;
    @(negedge CLK); dWEN[c] = 1'b0;
    @(negedge CLK); #1;
    checks++;
    if (ram[ix(base)] !== exp_mem[ix(base)] || ram[ix(base) + 1] !== exp_mem[ix(base) + 1] || dwait !== 2'b11)
      $display("FAIL wb_mem_image %h: got %h %h dwait=%b want %h %h 11", base, ram[ix(base)], ram[ix(base) + 1], dwait,
               exp_mem[ix(base)], exp_mem[ix(base) + 1]);
    else passed++;
    model_last = c;
  endtask

  task automatic test_back_to_back(input int exp_first);
    word_t base [2];
    word_t dat [2][2];
    int    w [2];
    int    first = -1;
    int    cyc = 0;
    base[0] = rand_base();
    base[1] = base[0] ^ 32'h200;
    for (int c = 0; c < 2; c++) begin
      w[c] = 0; dat[c][0] = $urandom; dat[c][1] = $urandom;
    end
    while ((w[0] < 2 || w[1] < 2) && cyc < 200) begin
      @(negedge CLK); cyc++;
      for (int c = 0; c < 2; c++) begin
        dWEN[c] = (w[c] < 2);
        if (w[c] < 2) begin
          daddr[c] = base[c] + word_t'(4 * w[c]); dstore[c] = dat[c][w[c]];
        end
      end
      #1;
      for (int c = 0; c < 2; c++) begin
        if (dWEN[c] && dwait[c] == 1'b0) begin
          if (first < 0) first = c;
          checks++;
          if (ramWEN !== 1'b1 || ramaddr !== daddr[c] || ramstore !== dstore[c])
            $display("FAIL tie_wb_port core%0d: got wen=%b addr=%h data=%h want 1/%h/%h", c, ramWEN, ramaddr, ramstore, daddr[c], dstore[c]);
          else passed++;
          exp_mem[ix(daddr[c])] = dstore[c];
          w[c]++;
        end
      end
    end
    checks++;
    if (first != exp_first || w[0] != 2 || w[1] != 2)
      $display("FAIL tie_order: got first=%0d words=%0d/%0d want first=%0d words=2/2", first, w[0], w[1], exp_first);
    else passed++;
    @(negedge CLK); dWEN = '0;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (ram[ix(base[0])] !== dat[0][0] || ram[ix(base[0]) + 1] !== dat[0][1] ||
        ram[ix(base[1])] !== dat[1][0] || ram[ix(base[1]) + 1] !== dat[1][1])
      $display("FAIL tie_mem_image: got %h %h %h %h want %h %h %h %h", ram[ix(base[0])], ram[ix(base[0]) + 1],
               ram[ix(base[1])], ram[ix(base[1]) + 1], dat[0][0], dat[0][1], dat[1][0], dat[1][1]);
    else passed++;
    model_last = 1 - exp_first;
  endtask

  task automatic test_upgrade(input int c, input word_t a);
    int s = 1 - c;
    @(negedge CLK); cctrans[c] = 1'b1; ccwrite[c] = 1'b1; daddr[c] = a;
    repeat (3) begin
      @(negedge CLK); #1;
      checks++;
      if (ccwait[s] !== 1'b1 || ccinv[s] !== 1'b1 || ccsnoopaddr[s] !== a || (ramREN | ramWEN) !== 1'b0 || dwait !== 2'b11)
        $display("FAIL upgrade_inv core%0d: got wait=%b inv=%b addr=%h ram=%b%b dwait=%b want 1/1/%h/00/11",
                 s, ccwait[s], ccinv[s], ccsnoopaddr[s], ramREN, ramWEN, dwait, a);
      else passed++;
    end
    cctrans[s] = 1'b1;
    @(negedge CLK); clear_reqs(); #1;
    checks++;
    if (ccwait !== 2'b00 || ccinv !== 2'b00)
      $display("FAIL upgrade_release: got ccwait=%b ccinv=%b want 00/00", ccwait, ccinv);
    else passed++;
    model_last = c;
  endtask

  task automatic test_ram_error();
    word_t a = 32'h3C0;
    lat = 0; ram_err = 1'b1;
    @(negedge CLK); dWEN[0] = 1'b1; daddr[0] = a; dstore[0] = 32'h0BAD_C0DE;
    repeat (4) begin
      @(negedge CLK); #1;
      checks++;
      if (dwait !== 2'b11 || ramWEN !== 1'b1)
        $display("FAIL ram_error_stall: got dwait=%b wen=%b want 11/1", dwait, ramWEN);
      else passed++;
    end
    @(negedge CLK); dWEN[0] = 1'b0;
    @(negedge CLK); ram_err = 1'b0;
    @(negedge CLK); #1;
    checks++;
    if (ram[ix(a)] !== exp_mem[ix(a)])
      $display("FAIL ram_error_no_write: got %h want %h", ram[ix(a)], exp_mem[ix(a)]);
    else passed++;
    model_last = 0;
  endtask

  task automatic test_reset_mid();
    word_t base = 32'h280;
    int    cyc = 0;
    bit    hit = 1'b0;
    lat = 3;
    while (!hit && cyc < 50) begin
      @(negedge CLK); cyc++;
      dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = base;
      #1;
      if (ccwait[1]) begin
        cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = base; dstore[1] = 32'hFEED_F00D;
      end
      #1;
      if (ramWEN && ccwait[1]) hit = 1'b1;
    end
    checks++;
    if (!hit) $display("FAIL reset_mid_reach_c2c: got no C2C in %0d cycles want C2C", cyc);
    else passed++;
    nRST = 1'b0;
    #1;
    checks++;
    if ({dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore} !== {2'b11, 198'b0})
      $display("FAIL reset_mid_defaults: got dwait=%b ccwait=%b ren=%b wen=%b want defaults", dwait, ccwait, ramREN, ramWEN);
    else passed++;
    @(negedge CLK); clear_reqs();
    @(negedge CLK); nRST = 1'b1; #1;
    checks++;
    if (ram[ix(base)] !== exp_mem[ix(base)] || ram[ix(base) + 1] !== exp_mem[ix(base) + 1])
      $display("FAIL reset_mid_no_write: got %h %h want %h %h", ram[ix(base)], ram[ix(base) + 1],
               exp_mem[ix(base)], exp_mem[ix(base) + 1]);
    else passed++;
    model_last = 1;
    run_read(0, 32'h140, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_random(input int n);
    int    c;
    int    kind;
    word_t base;
    for (int i = 0; i < n; i++) begin
      c    = $urandom_range(0, 1);
      kind = $urandom_range(0, 3);
      base = rand_base();
      lat  = $urandom_range(0, 3);
      case (kind)
        0: run_read(c, base, 1'($urandom_range(0, 1)), 1'b0, '0, '0);
        1: run_read(c, base, 1'($urandom_range(0, 1)), 1'b1, $urandom, $urandom);
        2: run_wb(c, base, $urandom, $urandom);
        default: test_back_to_back((model_last == 0) ? 1 : 0);
      endcase
    end
  endtask

  initial begin
    test_reset();
    lat = 1;
    test_back_to_back(0);
    lat = 2;
    run_read(0, 32'h100, 1'b0, 1'b0, '0, '0);
    run_read(0, 32'h200, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    test_upgrade(0, 32'h300);
    test_ram_error();
    lat = 2;
    run_wb(1, 32'h0C0, 32'h1234_5678, 32'h9ABC_DEF0);
    test_back_to_back((model_last == 0) ? 1 : 0);
    test_random(14);
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
